// File: rtl/uart_boot_loader_if.sv
// Program-memory write port driven by the UART boot loader into the core's unified memory.
interface uart_boot_loader_if #(
   parameter int ADDR_W = 10
);
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_wdata;

   modport master (output mem_we, output mem_addr, output mem_wdata);
   modport slave  (input  mem_we, input  mem_addr, input  mem_wdata);
endinterface

// File: rtl/uart_boot_loader.sv
// UART (8N1) program loader: A5, length, data words, XOR checksum; holds the core in reset until verified.
// Optional mid-load idle abort is built only when BOOT_TIMEOUT_EN is defined.
module uart_boot_loader #(
   parameter int CLK_DIV     = 104,
   parameter int ADDR_W      = 10,
   parameter int TIMEOUT_CYC = 1200000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                uart_rx,
   uart_boot_loader_if.master  mem,
   output logic                cpu_rst,
   output logic                load_done,
   output logic                load_err
);
   localparam int CNT_W = $clog2(CLK_DIV);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLK_DIV / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLK_DIV - 1);
   localparam logic [16:0] MAX_LEN = 17'(2 ** ADDR_W);
   localparam logic [7:0]  HDR     = 8'hA5;

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

   localparam logic [2:0] ST_WAIT_HDR = 3'd0;
   localparam logic [2:0] ST_LEN_HI   = 3'd1;
   localparam logic [2:0] ST_LEN_LO   = 3'd2;
   localparam logic [2:0] ST_DATA_HI  = 3'd3;
   localparam logic [2:0] ST_DATA_LO  = 3'd4;
   localparam logic [2:0] ST_CHECK    = 3'd5;
   localparam logic [2:0] ST_RUN      = 3'd6;

   function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

   logic             rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d, rx_prev_q, rx_prev_d;
   logic [1:0]       rx_state_q, rx_state_d;
   logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shift_q, shift_d;
   logic             byte_vld_q, byte_vld_d, frame_err_q, frame_err_d;

   logic [2:0]        state_q, state_d;
   logic [7:0]        len_hi_q, len_hi_d, csum_q, csum_d;
   logic [ADDR_W:0]   remain_q, remain_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [15:0]       mem_wdata_q, mem_wdata_d;
   logic              cpu_rst_q, cpu_rst_d, load_done_q, load_done_d, load_err_q, load_err_d;
   logic [16:0]       len_s;
   logic              in_load_s, timeout_s;

   assign len_s     = {1'b0, len_hi_q, shift_q};
   assign in_load_s = (state_q != ST_WAIT_HDR) && (state_q != ST_RUN);

   // Receiver: synchroniser, start detect with glitch reject, mid-bit sampling, stop check
   always_comb begin
      rx_meta_d   = uart_rx;
      rx_sync_d   = rx_meta_q;
      rx_prev_d   = rx_sync_q;
      rx_state_d  = rx_state_q;
      baud_cnt_d  = baud_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      byte_vld_d  = 1'b0;
      frame_err_d = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (rx_prev_q && !rx_sync_q) begin
               rx_state_d = RX_START;
               baud_cnt_d = '0;
            end else begin
               rx_state_d = RX_IDLE;
            end
         end
         RX_START: begin
            if (baud_cnt_q == HALF_M1) begin
               baud_cnt_d = '0;
               bit_cnt_d  = 3'd0;
               rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end else begin
               baud_cnt_d = baud_cnt_q + CNT_W'(1);
            end
         end
         RX_DATA: begin
            if (baud_cnt_q == FULL_M1) begin
               baud_cnt_d = '0;
               shift_d    = {rx_sync_q, shift_q[7:1]};
               bit_cnt_d  = bit_cnt_q + 3'd1;
               rx_state_d = (bit_cnt_q == 3'd7) ? RX_STOP : RX_DATA;
            end else begin
               baud_cnt_d = baud_cnt_q + CNT_W'(1);
            end
         end
         RX_STOP: begin
            if (baud_cnt_q == FULL_M1) begin
               baud_cnt_d  = '0;
               byte_vld_d  = rx_sync_q;
               frame_err_d = !rx_sync_q;
               rx_state_d  = RX_IDLE;
            end else begin
               baud_cnt_d = baud_cnt_q + CNT_W'(1);
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // Receiver registers
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q   <= 1'b1;
         rx_sync_q   <= 1'b1;
         rx_prev_q   <= 1'b1;
         rx_state_q  <= RX_IDLE;
         baud_cnt_q  <= '0;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 8'h00;
         byte_vld_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         rx_meta_q   <= rx_meta_d;
         rx_sync_q   <= rx_sync_d;
         rx_prev_q   <= rx_prev_d;
         rx_state_q  <= rx_state_d;
         baud_cnt_q  <= baud_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         byte_vld_q  <= byte_vld_d;
         frame_err_q <= frame_err_d;
      end
   end

`ifdef BOOT_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;

   assign timeout_s = in_load_s && (idle_cnt_q == TO_W'(TIMEOUT_CYC));

   // Idle counter: cleared by every byte, runs only while a load is in progress
   always_comb begin
      if (byte_vld_q || !in_load_s || timeout_s) begin
         idle_cnt_d = '0;
      end else begin
         idle_cnt_d = idle_cnt_q + TO_W'(1);
      end
   end

   // Idle counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         idle_cnt_q <= '0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
      end
   end
`else
   logic unused_timeout_s;
   assign unused_timeout_s = (TIMEOUT_CYC > 0);
   assign timeout_s        = 1'b0;
`endif

   // Load protocol FSM; the address advances the cycle after each write strobe
   always_comb begin
      state_d     = state_q;
      len_hi_d    = len_hi_q;
      remain_d    = remain_q;
      csum_d      = csum_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_we_q ? (mem_addr_q + ADDR_W'(1)) : mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      load_done_d = load_done_q;
      load_err_d  = load_err_q;
      if (byte_vld_q) begin
         case (state_q)
            ST_WAIT_HDR, ST_RUN: begin
               if (shift_q == HDR) begin
                  load_err_d  = 1'b0;
                  load_done_d = 1'b0;
                  csum_d      = 8'h00;
                  mem_addr_d  = '0;
                  state_d     = ST_LEN_HI;
               end else begin
                  state_d = state_q;
               end
            end
            ST_LEN_HI: begin
               len_hi_d = shift_q;
               state_d  = ST_LEN_LO;
            end
            ST_LEN_LO: begin
               if (len_s > MAX_LEN) begin
                  load_err_d = 1'b1;
                  state_d    = ST_WAIT_HDR;
               end else if (len_s == 17'd0) begin
                  state_d = ST_CHECK;
               end else begin
                  remain_d = len_s[ADDR_W:0];
                  state_d  = ST_DATA_HI;
               end
            end
            ST_DATA_HI: begin
               mem_wdata_d = {shift_q, mem_wdata_q[7:0]};
               csum_d      = csum_fold(csum_q, shift_q);
               state_d     = ST_DATA_LO;
            end
            ST_DATA_LO: begin
               mem_wdata_d = {mem_wdata_q[15:8], shift_q};
               csum_d      = csum_fold(csum_q, shift_q);
               mem_we_d    = 1'b1;
               remain_d    = remain_q - (ADDR_W + 1)'(1);
               state_d     = (remain_q == (ADDR_W + 1)'(1)) ? ST_CHECK : ST_DATA_HI;
            end
            ST_CHECK: begin
               if (shift_q == csum_q) begin
                  load_done_d = 1'b1;
                  state_d     = ST_RUN;
               end else begin
                  load_err_d = 1'b1;
                  state_d    = ST_WAIT_HDR;
               end
            end
            default: state_d = ST_WAIT_HDR;
         endcase
      end else if ((frame_err_q && in_load_s) || timeout_s) begin
         load_err_d = 1'b1;
         state_d    = ST_WAIT_HDR;
      end else begin
         state_d = state_q;
      end
      cpu_rst_d = (state_d != ST_RUN);
   end

   // Loader registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_WAIT_HDR;
         len_hi_q    <= 8'h00;
         remain_q    <= '0;
         csum_q      <= 8'h00;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 16'h0000;
         cpu_rst_q   <= 1'b1;
         load_done_q <= 1'b0;
         load_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_hi_q    <= len_hi_d;
         remain_q    <= remain_d;
         csum_q      <= csum_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_rst_q   <= cpu_rst_d;
         load_done_q <= load_done_d;
         load_err_q  <= load_err_d;
      end
   end

   assign mem.mem_we    = mem_we_q;
   assign mem.mem_addr  = mem_addr_q;
   assign mem.mem_wdata = mem_wdata_q;
   assign cpu_rst       = cpu_rst_q;
   assign load_done     = load_done_q;
   assign load_err      = load_err_q;
endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: protocol vectors, corner sequences and random packets vs a byte-level model.
module tb_uart_boot_loader;
   localparam int CLK_DIV = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic uart_rx = 1'b1;
   logic cpu_rst, load_done, load_err;

   uart_boot_loader_if #(.ADDR_W(10)) mem_bus ();

   uart_boot_loader #(.CLK_DIV(CLK_DIV), .ADDR_W(10), .TIMEOUT_CYC(50)) dut (
      .clk       (clk),
      .rst       (rst),
      .uart_rx   (uart_rx),
      .mem       (mem_bus),
      .cpu_rst   (cpu_rst),
      .load_done (load_done),
      .load_err  (load_err)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;
   logic [25:0] log_q[$];
   logic [25:0] exp_q[$];

   // model of the loader at packet-byte granularity (0 = not inside a packet)
   int m_pos, m_n;
   logic [7:0] m_sum, m_hi;
   bit m_done, m_err;

   always @(negedge clk) begin
      if (mem_bus.mem_we === 1'b1) log_q.push_back({mem_bus.mem_addr, mem_bus.mem_wdata});
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic check_writes(input string tag);
      int ne = exp_q.size();
      int nl = log_q.size();
      chk({tag, "_nwr"}, nl, ne);
      for (int i = 0; i < ne && i < nl; i++) chk({tag, "_wr"}, log_q[i], exp_q[i]);
      exp_q.delete();
      log_q.delete();
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      uart_rx = 1'b0;
      repeat (CLK_DIV) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (CLK_DIV) @(posedge clk);
         #1;
      end
      uart_rx = stop;
      repeat (CLK_DIV) @(posedge clk);
      #1;
      uart_rx = 1'b1;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic model_reset();
      m_pos = 0; m_n = 0; m_sum = 8'h00; m_hi = 8'h00; m_done = 1'b0; m_err = 1'b0;
      exp_q.delete();
      log_q.delete();
   endtask

   task automatic model_byte(input logic [7:0] b);
      int idx;
      if (m_pos == 0) begin
         if (b == 8'hA5) begin m_pos = 1; m_done = 1'b0; m_err = 1'b0; m_sum = 8'h00; end
      end else if (m_pos == 1) begin
         m_hi = b; m_pos = 2;
      end else if (m_pos == 2) begin
         m_n = int'({m_hi, b});
         if (m_n > 1024) begin m_err = 1'b1; m_pos = 0; end
         else m_pos = 3;
      end else if (m_pos < 3 + 2 * m_n) begin
         idx = m_pos - 3;
         m_sum = m_sum ^ b;
         if (idx % 2 == 0) m_hi = b;
         else exp_q.push_back({10'((idx / 2) % 1024), m_hi, b});
         m_pos++;
      end else begin
         if (b == m_sum) m_done = 1'b1;
         else m_err = 1'b1;
         m_pos = 0;
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_done"}, load_done, m_done);
      chk({tag, "_err"}, load_err, m_err);
      chk({tag, "_cpu_rst"}, cpu_rst, !m_done);
      check_writes(tag);
   endtask

   typedef struct {
      int          nb;
      logic [63:0] bytes;
      int          nwr;
      logic [25:0] w0;
      logic [25:0] w1;
      logic        done;
      logic        err;
      logic        crst;
   } vec_t;

   vec_t vecs[5];

   initial begin
      logic [7:0] pkt[$];
      logic [7:0] b;
      logic [7:0] sum;
      int n;

      vecs[0] = '{8, 64'hA5_00_02_12_34_AB_CD_40, 2, {10'd0, 16'h1234}, {10'd1, 16'hABCD}, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{6, 64'hA5_00_01_00_FF_00_00_00, 1, {10'd0, 16'h00FF}, 26'd0, 1'b0, 1'b1, 1'b1};
      vecs[2] = '{6, 64'hA5_00_01_00_FF_FF_00_00, 1, {10'd0, 16'h00FF}, 26'd0, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{4, 64'hA5_00_00_00_00_00_00_00, 0, 26'd0, 26'd0, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{3, 64'hA5_04_01_00_00_00_00_00, 0, 26'd0, 26'd0, 1'b0, 1'b1, 1'b1};

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_cpu_rst", cpu_rst, 1'b1);
      chk("rst_mem_we", mem_bus.mem_we, 1'b0);
      chk("rst_mem_addr", mem_bus.mem_addr, 10'd0);
      chk("rst_mem_wdata", mem_bus.mem_wdata, 16'h0000);
      chk("rst_load_done", load_done, 1'b0);
      chk("rst_load_err", load_err, 1'b0);

      for (int v = 0; v < 5; v++) begin
         exp_q.delete();
         log_q.delete();
         for (int i = 0; i < vecs[v].nb; i++) begin
            b = vecs[v].bytes[63 - 8 * i -: 8];
            send_byte(b, 1'b1);
         end
         if (vecs[v].nwr > 0) exp_q.push_back(vecs[v].w0);
         if (vecs[v].nwr > 1) exp_q.push_back(vecs[v].w1);
         chk($sformatf("vec%0d_done", v), load_done, vecs[v].done);
         chk($sformatf("vec%0d_err", v), load_err, vecs[v].err);
         chk($sformatf("vec%0d_cpu_rst", v), cpu_rst, vecs[v].crst);
         check_writes($sformatf("vec%0d", v));
      end

      // framing error while a data word is expected, then stray bytes must be ignored
      send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
      chk("frm_err_cleared", load_err, 1'b0);
      send_byte(8'h12, 1'b0);
      chk("frm_err", load_err, 1'b1);
      chk("frm_cpu_rst", cpu_rst, 1'b1);
      chk("frm_done", load_done, 1'b0);
      send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1);
      chk("frm_err_hold", load_err, 1'b1);
      check_writes("frm");

      // one-clock low glitch must not produce a byte or disturb the next frame
      uart_rx = 1'b0;
      @(posedge clk);
      #1;
      uart_rx = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      chk("glitch_err_hold", load_err, 1'b1);
      check_writes("glitch");
      send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
      chk("glitch_after_done", load_done, 1'b1);
      chk("glitch_after_err", load_err, 1'b0);

      // header while running re-asserts core reset
      chk("run_cpu_rst_pre", cpu_rst, 1'b0);
      send_byte(8'hA5, 1'b1);
      chk("reload_cpu_rst", cpu_rst, 1'b1);
      chk("reload_done", load_done, 1'b0);
      send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
      chk("reload_done2", load_done, 1'b1);

      // reset in the middle of a load
      send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h04, 1'b1);
      send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1); send_byte(8'h56, 1'b1);
      exp_q.push_back({10'd0, 16'h1234});
      check_writes("midload");
      chk("midload_addr", mem_bus.mem_addr, 10'd1);
      pulse_rst();
      chk("mrst_cpu_rst", cpu_rst, 1'b1);
      chk("mrst_mem_we", mem_bus.mem_we, 1'b0);
      chk("mrst_mem_addr", mem_bus.mem_addr, 10'd0);
      chk("mrst_mem_wdata", mem_bus.mem_wdata, 16'h0000);
      chk("mrst_done", load_done, 1'b0);
      chk("mrst_err", load_err, 1'b0);
      send_byte(8'h78, 1'b1); send_byte(8'h9A, 1'b1);
      check_writes("mrst_ignored");
      chk("mrst_ignored_err", load_err, 1'b0);
      send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
      send_byte(8'hCA, 1'b1); send_byte(8'hFE, 1'b1); send_byte(8'h34, 1'b1);
      exp_q.push_back({10'd0, 16'hCAFE});
      check_writes("resume");
      chk("resume_done", load_done, 1'b1);

      // idle mid-load: abort only when the timeout is built
      send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1);
      repeat (70) @(posedge clk);
      #1;
`ifdef BOOT_TIMEOUT_EN
      chk("idle_err", load_err, 1'b1);
`else
      chk("idle_err", load_err, 1'b0);
`endif
      send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
`ifdef BOOT_TIMEOUT_EN
      chk("idle_done", load_done, 1'b0);
      chk("idle_err2", load_err, 1'b1);
`else
      chk("idle_done", load_done, 1'b1);
      chk("idle_err2", load_err, 1'b0);
`endif

      // randomized packets against the model
      pulse_rst();
      model_reset();
      for (int p = 0; p < 25; p++) begin
         pkt.delete();
         if ($urandom_range(0, 5) == 0) pkt.push_back(8'($urandom_range(0, 255)));
         n = $urandom_range(0, 5);
         pkt.push_back(8'hA5);
         if ($urandom_range(0, 9) == 0) pkt.push_back(8'($urandom_range(4, 255)));
         else pkt.push_back(8'h00);
         pkt.push_back(8'(n));
         sum = 8'h00;
         for (int i = 0; i < 2 * n; i++) begin
            b = 8'($urandom_range(0, 255));
            sum = sum ^ b;
            pkt.push_back(b);
         end
         if ($urandom_range(0, 4) == 0) sum = sum ^ 8'($urandom_range(1, 255));
         pkt.push_back(sum);
         foreach (pkt[i]) begin
            if ($urandom_range(0, 24) == 0) begin
               send_byte(pkt[i], 1'b0);
               if (m_pos != 0) begin m_err = 1'b1; m_pos = 0; end
            end else begin
               send_byte(pkt[i], 1'b1);
               model_byte(pkt[i]);
            end
            check_model($sformatf("rnd%0d_%0d", p, i));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
